// File: rtl/divider_rv32m.sv
// Multicycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow finish on a one-cycle short path.
module divider_rv32m #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [XLEN-1:0] op_A_i,
    input  logic [XLEN-1:0] op_B_i,
    input  logic            signed_i,
    input  logic            rem_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   div_q, div_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic              sel_rem_q, sel_rem_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              ready_q, busy_q, done_q;

    logic              div_zero_c, overflow_c, accept_c, ge_c;
    logic [XLEN:0]     rem_sh_c, diff_c;
    logic [XLEN-1:0]   q_fix_c, r_fix_c;

    // Corner detection, trial subtraction and sign fix-up datapath
    always_comb begin
        accept_c   = start_i && !kill_i && (state_q == IDLE || state_q == DONE);
        div_zero_c = (op_B_i == '0);
        overflow_c = signed_i && (op_A_i == MIN_NEG) && (op_B_i == '1);
        rem_sh_c   = {rem_q, quo_q[XLEN-1]};
        diff_c     = rem_sh_c - {1'b0, div_q};
        ge_c       = (rem_sh_c >= {1'b0, div_q});
        q_fix_c    = q_neg_q ? (-quo_q) : quo_q;
        r_fix_c    = r_neg_q ? (-rem_q) : rem_q;
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        sel_rem_d = sel_rem_q;
        result_d  = result_q;

        if (kill_i) begin
            state_d = IDLE;
        end else if (accept_c) begin
            sel_rem_d = rem_i;
            q_neg_d   = signed_i && (op_A_i[XLEN-1] ^ op_B_i[XLEN-1]);
            r_neg_d   = signed_i && op_A_i[XLEN-1];
            rem_d     = '0;
            cnt_d     = '0;
            quo_d     = (signed_i && op_A_i[XLEN-1]) ? (-op_A_i) : op_A_i;
            div_d     = (signed_i && op_B_i[XLEN-1]) ? (-op_B_i) : op_B_i;
            if (div_zero_c) begin
                result_d = rem_i ? op_A_i : '1;
                state_d  = DONE;
            end else if (overflow_c) begin
                result_d = rem_i ? '0 : MIN_NEG;
                state_d  = DONE;
            end else begin
                state_d  = CALC;
            end
        end else begin
            case (state_q)
                CALC: begin
                    rem_d = XLEN'(ge_c ? diff_c : rem_sh_c);
                    quo_d = {quo_q[XLEN-2:0], ge_c};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    result_d = sel_rem_q ? r_fix_c : q_fix_c;
                    state_d  = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            cnt_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            sel_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            sel_rem_q <= sel_rem_d;
            result_q  <= result_d;
            ready_q   <= (state_d == IDLE) || (state_d == DONE);
            busy_q    <= (state_d == CALC) || (state_d == FIX);
            done_q    <= (state_d == DONE);
        end
    end

    assign ready_o  = ready_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule
